carp_bytewrite_ram: RTL and testbench

CARP_BYTEWRITE_RAM -- requirements
Module: carp_bytewrite_ram

---
 rtl/carp_bytewrite_ram.sv | 196 +++++++++++++++++++
 tb/tb_carp_bytewrite_ram.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/carp_bytewrite_ram.sv
// Dual-port byte-writable RAM with read-first/write-first read modes, an
// optional output register and a one-word-per-cycle zero-fill engine.
module carp_bytewrite_ram #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0,
  parameter int CLEAR_EN   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  pA_en_i,
  input  logic [NUM_COL-1:0]    pA_strobe_i,
  input  logic [ADDR_WIDTH-1:0] pA_addr_i,
  input  logic [DATA_WIDTH-1:0] pA_data_i,
  input  logic                  pB_en_i,
  input  logic [NUM_COL-1:0]    pB_strobe_i,
  input  logic [ADDR_WIDTH-1:0] pB_addr_i,
  input  logic [DATA_WIDTH-1:0] pB_data_i,
  output logic [DATA_WIDTH-1:0] pA_data_o,
  output logic                  pA_valid_o,
  output logic [DATA_WIDTH-1:0] pB_data_o,
  output logic                  pB_valid_o,
  output logic                  busy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_clrAddr;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic                  w_acc    [2];
  logic [NUM_COL-1:0]    w_strb   [2];
  logic [ADDR_WIDTH-1:0] w_addr   [2];
  logic [DATA_WIDTH-1:0] w_wdat   [2];
  logic [DATA_WIDTH-1:0] w_rdWord [2];

  logic                  r_s1Valid [2];
  logic [DATA_WIDTH-1:0] r_s1Data  [2];
  logic                  w_outValid [2];
  logic [DATA_WIDTH-1:0] w_outData  [2];

  assign w_acc[0]  = pA_en_i & ~r_busy & ~rst_i;
  assign w_acc[1]  = pB_en_i & ~r_busy & ~rst_i;
  assign w_strb[0] = pA_strobe_i;
  assign w_strb[1] = pB_strobe_i;
  assign w_addr[0] = pA_addr_i;
  assign w_addr[1] = pB_addr_i;
  assign w_wdat[0] = pA_data_i;
  assign w_wdat[1] = pB_data_i;

  // Write-first merges this cycle's column writes over the stored word,
  // port B first so port A overrides it on shared columns.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdWord[p] = r_mem[w_addr[p]];
    end
    if (RD_MODE != 0) begin
      for (int p = 0; p < 2; p++) begin
        for (int q = 1; q >= 0; q--) begin
          for (int c = 0; c < NUM_COL; c++) begin
            if (w_acc[q] && (w_addr[q] == w_addr[p]) && w_strb[q][c]) begin
              w_rdWord[p][c*COL_WIDTH +: COL_WIDTH] = w_wdat[q][c*COL_WIDTH +: COL_WIDTH];
            end
          end
        end
      end
    end
  end

  // Array has no reset; the clear engine and the ports never write together
  // because accesses are refused while busy.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_busy) begin
        r_mem[r_clrAddr] <= '0;
      end else begin
        for (int q = 1; q >= 0; q--) begin
          if (w_acc[q]) begin
            for (int c = 0; c < NUM_COL; c++) begin
              if (w_strb[q][c]) begin
                r_mem[w_addr[q]][c*COL_WIDTH +: COL_WIDTH] <= w_wdat[q][c*COL_WIDTH +: COL_WIDTH];
              end
            end
          end
        end
      end
    end
  end

  // Clear engine. After reset r_busy is already set while still in IDLE so
  // that address 0 is written in the very first cycle after release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_clrAddr <= '0;
      r_busy    <= (CLEAR_EN != 0);
    end else begin
      case (r_state)
        IDLE: begin
          if (r_busy) begin
            r_state   <= CLEAR;
            r_clrAddr <= r_clrAddr + 1'b1;
          end else if (clear_i) begin
            r_state   <= CLEAR;
            r_busy    <= 1'b1;
            r_clrAddr <= '0;
          end
        end
        CLEAR: begin
          if (r_clrAddr == '1) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_clrAddr <= '0;
          end else begin
            r_clrAddr <= r_clrAddr + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_clrAddr <= '0;
        end
      endcase
    end
  end

  // Data is captured only on an accepted access so the outputs hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < 2; p++) begin
        r_s1Valid[p] <= 1'b0;
        r_s1Data[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_s1Valid[p] <= w_acc[p];
        if (w_acc[p]) begin
          r_s1Data[p] <= w_rdWord[p];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_outReg
      logic                  r_s2Valid [2];
      logic [DATA_WIDTH-1:0] r_s2Data  [2];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int p = 0; p < 2; p++) begin
            r_s2Valid[p] <= 1'b0;
            r_s2Data[p]  <= '0;
          end
        end else begin
          for (int p = 0; p < 2; p++) begin
            r_s2Valid[p] <= r_s1Valid[p];
            if (r_s1Valid[p]) begin
              r_s2Data[p] <= r_s1Data[p];
            end
          end
        end
      end

      for (genvar p = 0; p < 2; p++) begin : g_port
        assign w_outValid[p] = r_s2Valid[p];
        assign w_outData[p]  = r_s2Data[p];
      end
    end else begin : g_noOutReg
      for (genvar p = 0; p < 2; p++) begin : g_port
        assign w_outValid[p] = r_s1Valid[p];
        assign w_outData[p]  = r_s1Data[p];
      end
    end
  endgenerate

  assign pA_valid_o = w_outValid[0];
  assign pA_data_o  = w_outData[0];
  assign pB_valid_o = w_outValid[1];
  assign pB_data_o  = w_outData[1];
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_carp_bytewrite_ram.sv
// Bench for carp_bytewrite_ram: a read-first/no-output-register instance and a
// write-first/output-register instance share stimulus and a scoreboard model.
module tb_carp_bytewrite_ram;

  logic        clk_i;
  logic        rst_i;
  logic        clear_i;
  logic        pA_en_i, pB_en_i;
  logic [3:0]  pA_strobe_i, pB_strobe_i;
  logic [3:0]  pA_addr_i, pB_addr_i;
  logic [31:0] pA_data_i, pB_data_i;

  logic [31:0] a0Data, b0Data, a1Data, b1Data;
  logic        a0Valid, b0Valid, a1Valid, b1Valid;
  logic        busy0, busy1;

  carp_bytewrite_ram #(
    .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4),
    .RD_MODE(0), .OUT_REG(0), .CLEAR_EN(1)
  ) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .pA_en_i(pA_en_i), .pA_strobe_i(pA_strobe_i), .pA_addr_i(pA_addr_i), .pA_data_i(pA_data_i),
    .pB_en_i(pB_en_i), .pB_strobe_i(pB_strobe_i), .pB_addr_i(pB_addr_i), .pB_data_i(pB_data_i),
    .pA_data_o(a0Data), .pA_valid_o(a0Valid),
    .pB_data_o(b0Data), .pB_valid_o(b0Valid),
    .busy_o(busy0)
  );

  carp_bytewrite_ram #(
    .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4),
    .RD_MODE(1), .OUT_REG(1), .CLEAR_EN(1)
  ) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .pA_en_i(pA_en_i), .pA_strobe_i(pA_strobe_i), .pA_addr_i(pA_addr_i), .pA_data_i(pA_data_i),
    .pB_en_i(pB_en_i), .pB_strobe_i(pB_strobe_i), .pB_addr_i(pB_addr_i), .pB_data_i(pB_data_i),
    .pA_data_o(a1Data), .pA_valid_o(a1Valid),
    .pB_data_o(b1Data), .pB_valid_o(b1Valid),
    .busy_o(busy1)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    logic [31:0] data;
  } expItem_t;

  // Streams: 0 = u0 port A, 1 = u0 port B, 2 = u1 port A, 3 = u1 port B.
  expItem_t    sbQ [4][$];
  logic [31:0] lastData [4];
  string       sName [4] = '{"u0A", "u0B", "u1A", "u1B"};

  logic [31:0] model [16];
  bit          modelBusy;
  int          clrCnt;
  int          cycle;
  int          passCount;
  int          failCount;
  int          checkCount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cycle);
    end
  endtask

  task automatic checkOutput();
    logic        v;
    logic [31:0] d;
    expItem_t    e;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       begin v = a0Valid; d = a0Data; end
        1:       begin v = b0Valid; d = b0Data; end
        2:       begin v = a1Valid; d = a1Data; end
        default: begin v = b1Valid; d = b1Data; end
      endcase
      if (sbQ[s].size() > 0 && sbQ[s][0].due == cycle) begin
        e = sbQ[s].pop_front();
        check({sName[s], " valid"}, {31'b0, v}, 32'd1);
        check({sName[s], " data"}, d, e.data);
        lastData[s] = e.data;
      end else begin
        check({sName[s], " idle valid"}, {31'b0, v}, 32'd0);
        check({sName[s], " hold data"}, d, lastData[s]);
      end
    end
  endtask

  task automatic applyStimulus(
    input bit rst, input bit clr,
    input bit enA, input logic [3:0] sA, input logic [3:0] aA, input logic [31:0] dA,
    input bit enB, input logic [3:0] sB, input logic [3:0] aB, input logic [31:0] dB
  );
    bit          accA, accB;
    logic [31:0] rdA0, rdB0, rdA1, rdB1;
    expItem_t    e;
    rst_i = rst; clear_i = clr;
    pA_en_i = enA; pA_strobe_i = sA; pA_addr_i = aA; pA_data_i = dA;
    pB_en_i = enB; pB_strobe_i = sB; pB_addr_i = aB; pB_data_i = dB;

    check("busy u0", {31'b0, busy0}, {31'b0, modelBusy});
    check("busy u1", {31'b0, busy1}, {31'b0, modelBusy});

    accA = enA && !modelBusy && !rst;
    accB = enB && !modelBusy && !rst;
    rdA0 = model[aA];
    rdB0 = model[aB];
    if (!rst) begin
      if (modelBusy) begin
        model[clrCnt] = 32'h0;
      end else begin
        for (int c = 0; c < 4; c++)
          if (accB && sB[c]) model[aB][c*8 +: 8] = dB[c*8 +: 8];
        for (int c = 0; c < 4; c++)
          if (accA && sA[c]) model[aA][c*8 +: 8] = dA[c*8 +: 8];
      end
    end
    rdA1 = model[aA];
    rdB1 = model[aB];

    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        sbQ[s].delete();
        lastData[s] = 32'h0;
      end
      modelBusy = 1'b1;
      clrCnt    = 0;
    end else begin
      if (accA) begin
        e.due = cycle + 1; e.data = rdA0; sbQ[0].push_back(e);
        e.due = cycle + 2; e.data = rdA1; sbQ[2].push_back(e);
      end
      if (accB) begin
        e.due = cycle + 1; e.data = rdB0; sbQ[1].push_back(e);
        e.due = cycle + 2; e.data = rdB1; sbQ[3].push_back(e);
      end
      if (modelBusy) begin
        clrCnt++;
        if (clrCnt == 16) begin
          modelBusy = 1'b0;
          clrCnt    = 0;
        end
      end else if (clr) begin
        modelBusy = 1'b1;
        clrCnt    = 0;
      end
    end

    @(posedge clk_i);
    cycle++;
    @(negedge clk_i);
    checkOutput();
  endtask

  task automatic randomTraffic(input bit rst, input bit clr);
    applyStimulus(rst, clr,
                  1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    passCount = 0; failCount = 0; checkCount = 0; cycle = 0;
    rst_i = 1'b1; clear_i = 1'b0;
    pA_en_i = 1'b0; pA_strobe_i = '0; pA_addr_i = '0; pA_data_i = '0;
    pB_en_i = 1'b0; pB_strobe_i = '0; pB_addr_i = '0; pB_data_i = '0;
    for (int s = 0; s < 4; s++) lastData[s] = 32'h0;
    modelBusy = 1'b1;
    clrCnt    = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);

    $display("[TB] reset with active port inputs, then power-up clear");
    applyStimulus(1, 1, 1, 4'hF, 4'h2, 32'hDEADBEEF, 1, 4'hF, 4'h9, 32'hCAFEF00D);
    applyStimulus(1, 0, 1, 4'hF, 4'h3, 32'h12345678, 1, 4'hF, 4'hA, 32'h87654321);
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 1, 1, 4'hF, 4'(i), 32'hFFFF0000 | i, 1, 4'hF, 4'(15 - i), 32'h0000FFFF);

    $display("[TB] read all addresses after clear");
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 0, 1, 4'h0, 4'(i), 32'h0, 1, 4'h0, 4'(15 - i), 32'h0);

    $display("[TB] read-first vs write-first with partial strobes");
    applyStimulus(0, 0, 1, 4'hF, 4'h5, 32'h11223344, 0, 4'h0, 4'h0, 32'h0);
    applyStimulus(0, 0, 1, 4'b0101, 4'h5, 32'hAABBCCDD, 0, 4'h0, 4'h0, 32'h0);
    applyStimulus(0, 0, 1, 4'b0000, 4'h5, 32'h0, 0, 4'h0, 4'h0, 32'h0);

    $display("[TB] same-address write collision");
    applyStimulus(0, 0, 1, 4'b0011, 4'h3, 32'h0000A1A2, 1, 4'b0110, 4'h3, 32'h00B1B200);
    applyStimulus(0, 0, 1, 4'b0000, 4'h3, 32'h0, 1, 4'b0000, 4'h3, 32'h0);

    $display("[TB] preload then back-to-back reads");
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 1, 4'hF, 4'(i), 32'hA0000000 + 32'(i * 32'h01010101),
                    1, 4'hF, 4'(i + 8), 32'hB0000000 + 32'(i));
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 1, 4'h0, 4'(i), 32'h0, 1, 4'h0, 4'(i), 32'h0);
    idle(3);

    $display("[TB] random traffic with collisions");
    for (int i = 0; i < 40; i++) randomTraffic(0, 0);
    idle(2);

    $display("[TB] clear during traffic, second clear, reset mid-clear");
    applyStimulus(0, 0, 1, 4'hF, 4'h1, 32'h5A5A5A5A, 1, 4'h0, 4'h2, 32'h0);
    applyStimulus(0, 1, 1, 4'h0, 4'h1, 32'h0, 1, 4'hF, 4'h2, 32'h3C3C3C3C);
    for (int i = 0; i < 20 && clrCnt != 7; i++)
      randomTraffic(0, clrCnt == 4);
    check("clear counter reached 7", 32'(clrCnt), 32'd7);
    applyStimulus(1, 0, 1, 4'hF, 4'h4, 32'h77777777, 1, 4'hF, 4'h5, 32'h88888888);
    applyStimulus(1, 0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 16; i++) randomTraffic(0, 0);
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 0, 1, 4'h0, 4'(i), 32'h0, 1, 4'h0, 4'(i ^ 5), 32'h0);
    idle(3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
